// File: rtl/pcap_dma_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pcap_dma_sequencer
// Brief    : Drains the PCAP sample FIFO into software-supplied host buffers
//            as write bursts; PCAP_DMA_STATS_EN adds word/buffer counters.
// Revision : 1.0
// ============================================================================
module pcap_dma_sequencer #(
  parameter int BURST_LEN = 16,
  parameter int ADDR_AW   = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        complete_i,
  input  logic [10:0] fifo_count_i,
  input  logic [31:0] dma_addr_i,
  input  logic        dma_addr_wstb_i,
  input  logic [31:0] block_size_i,
  input  logic [31:0] timeout_i,
  input  logic        irq_ack_i,
  output logic        dma_req_o,
  input  logic        dma_ack_i,
  output logic [31:0] dma_addr_o,
  output logic [7:0]  dma_len_o,
  input  logic        dma_done_i,
  output logic        irq_o,
  output logic [7:0]  irq_status_o,
  output logic [15:0] smpl_count_o,
`ifdef PCAP_DMA_STATS_EN
  output logic [31:0] total_words_o,
  output logic [15:0] buffers_o,
`endif
  output logic        active_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPEN   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_XFER   = 3'd4;
  localparam logic [2:0] S_CLOSE  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam int          DEPTH       = 1 << ADDR_AW;
  localparam logic [10:0] C_BURST_FC  = 11'(BURST_LEN);
  localparam logic [29:0] C_BURST_WL  = 30'(BURST_LEN);
  localparam logic [8:0]  C_BURST_LEN = 9'(BURST_LEN);

  logic [31:0]        tbl_mem [DEPTH];
  logic [ADDR_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_AW:0]   tbl_cnt_q;
  logic               w_tbl_full, w_tbl_empty, w_push, w_pop;

  logic [2:0]  state_q, state_d;
  logic        enable_q, active_q, active_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [29:0] words_left_q, words_left_d;
  logic [15:0] buf_words_q, buf_words_d;
  logic [8:0]  len_q, len_d;
  logic [31:0] tmr_q, tmr_d;
  logic        final_q, final_d, disarm_q, disarm_d;
  logic [7:0]  status_q, status_d, w_set;
  logic        irq_q;
  logic [15:0] smpl_q, smpl_d;
  logic        w_rise, w_tmr_exp;

  assign w_tbl_full  = tbl_cnt_q[ADDR_AW];
  assign w_tbl_empty = (tbl_cnt_q == '0);
  assign w_push      = dma_addr_wstb_i & ~w_tbl_full;
  assign w_rise      = enable_i & ~enable_q;
  assign w_tmr_exp   = (timeout_i != 32'd0) && (tmr_q == timeout_i - 32'd1);

  always_ff @(posedge clk_i) begin
    if (w_push) tbl_mem[wr_ptr_q] <= dma_addr_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tbl_cnt_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   tbl_cnt_q <= tbl_cnt_q + 1'b1;
        2'b01:   tbl_cnt_q <= tbl_cnt_q - 1'b1;
        default: tbl_cnt_q <= tbl_cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    buf_words_d  = buf_words_q;
    len_d        = len_q;
    final_d      = final_q;
    disarm_d     = disarm_q;
    smpl_d       = smpl_q;
    w_set        = 8'h00;
    w_pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_rise) begin
          state_d  = S_OPEN;
          active_d = 1'b1;
          final_d  = 1'b0;
          disarm_d = 1'b0;
        end
      end
      S_OPEN: begin
        if (!w_tbl_empty) begin
          w_pop        = 1'b1;
          cur_addr_d   = tbl_mem[rd_ptr_q];
          words_left_d = block_size_i[31:2];
          buf_words_d  = '0;
          state_d      = S_WAIT;
        end else begin
          w_set[3] = 1'b1;
          state_d  = S_FINISH;
        end
      end
      S_WAIT: begin
        if (fifo_count_i >= C_BURST_FC) begin
          len_d   = (words_left_q >= C_BURST_WL) ? C_BURST_LEN : words_left_q[8:0];
          state_d = S_REQ;
        end else if (fifo_count_i != 11'd0 && (complete_i || w_tmr_exp)) begin
          // A partial FIFO level is below BURST_LEN, so it always fits in len
          len_d    = ({19'd0, fifo_count_i} <= words_left_q) ? fifo_count_i[8:0]
                                                             : words_left_q[8:0];
          w_set[2] = ~complete_i;
          state_d  = S_REQ;
        end else if (complete_i) begin
          final_d = 1'b1;
          state_d = S_CLOSE;
        end else if (!enable_i) begin
          w_set[5] = 1'b1;
          final_d  = 1'b1;
          disarm_d = 1'b1;
          state_d  = S_CLOSE;
        end
      end
      S_REQ: begin
        if (dma_ack_i) state_d = S_XFER;
      end
      S_XFER: begin
        if (dma_done_i) begin
          cur_addr_d   = cur_addr_q + {21'd0, len_q, 2'b00};
          words_left_d = words_left_q - {21'd0, len_q};
          buf_words_d  = buf_words_q + {7'd0, len_q};
          state_d      = (words_left_q == {21'd0, len_q}) ? S_CLOSE : S_WAIT;
        end
      end
      S_CLOSE: begin
        smpl_d   = buf_words_q;
        w_set[0] = 1'b1;
        if (final_q) begin
          w_set[1] = ~disarm_q;
          state_d  = S_FINISH;
        end else begin
          state_d  = S_OPEN;
        end
      end
      S_FINISH: begin
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    w_set[4] = dma_addr_wstb_i & w_tbl_full;
  end

  // Timer runs only while lingering in WAIT_DATA with a partial FIFO level
  assign tmr_d = (state_q == S_WAIT && state_d == S_WAIT &&
                  fifo_count_i != 11'd0 && fifo_count_i < C_BURST_FC) ? tmr_q + 32'd1 : 32'd0;

  // Ack clears old flags; events raised in the same cycle survive
  assign status_d = (irq_ack_i ? 8'h00 : status_q) | w_set;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      enable_q     <= 1'b0;
      active_q     <= 1'b0;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      buf_words_q  <= '0;
      len_q        <= '0;
      tmr_q        <= '0;
      final_q      <= 1'b0;
      disarm_q     <= 1'b0;
      status_q     <= '0;
      irq_q        <= 1'b0;
      smpl_q       <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_i;
      active_q     <= active_d;
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
      buf_words_q  <= buf_words_d;
      len_q        <= len_d;
      tmr_q        <= tmr_d;
      final_q      <= final_d;
      disarm_q     <= disarm_d;
      status_q     <= status_d;
      irq_q        <= |status_d;
      smpl_q       <= smpl_d;
    end
  end

  assign dma_req_o    = (state_q == S_REQ);
  assign dma_addr_o   = cur_addr_q;
  assign dma_len_o    = len_q[7:0];
  assign irq_o        = irq_q;
  assign irq_status_o = status_q;
  assign smpl_count_o = smpl_q;
  assign active_o     = active_q;

`ifdef PCAP_DMA_STATS_EN
  logic [31:0] total_words_q;
  logic [15:0] buffers_q;
  logic [32:0] w_tw_sum;

  assign w_tw_sum = {1'b0, total_words_q} + {24'd0, len_q};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      total_words_q <= '0;
      buffers_q     <= '0;
    end else if (w_rise) begin
      total_words_q <= '0;
      buffers_q     <= '0;
    end else begin
      if (state_q == S_XFER && dma_done_i)
        total_words_q <= w_tw_sum[32] ? 32'hFFFF_FFFF : w_tw_sum[31:0];
      if (state_q == S_CLOSE && buffers_q != 16'hFFFF)
        buffers_q <= buffers_q + 16'd1;
    end
  end

  assign total_words_o = total_words_q;
  assign buffers_o     = buffers_q;
`else
  // Statistics counters are not built in this configuration.
`endif

  logic w_unused;
  assign w_unused = &{1'b0, block_size_i[1:0], len_q[8]};

endmodule
`default_nettype wire

// File: tb/tb_pcap_dma_sequencer.sv
`default_nettype none
// Scoreboard bench for pcap_dma_sequencer: random drain episodes and directed
// corner cases, predicted by a buffer-walk model of the address table.
module tb_pcap_dma_sequencer;
  localparam int BURST = 16;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i, complete_i;
  logic [10:0] fifo_count_i;
  logic [31:0] dma_addr_i, block_size_i, timeout_i;
  logic        dma_addr_wstb_i, irq_ack_i;
  logic        dma_req_o, dma_ack_i, dma_done_i;
  logic [31:0] dma_addr_o;
  logic [7:0]  dma_len_o;
  logic        irq_o, active_o;
  logic [7:0]  irq_status_o;
  logic [15:0] smpl_count_o;
`ifdef PCAP_DMA_STATS_EN
  logic [31:0] total_words_o;
  logic [15:0] buffers_o;
`endif

  always #5 clk_i = ~clk_i;

  int   avail;
  logic ack_mon, ack_dir;
  assign fifo_count_i = avail[10:0];
  assign irq_ack_i    = ack_mon | ack_dir;

  pcap_dma_sequencer #(.BURST_LEN(BURST), .ADDR_AW(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .complete_i(complete_i),
    .fifo_count_i(fifo_count_i), .dma_addr_i(dma_addr_i), .dma_addr_wstb_i(dma_addr_wstb_i),
    .block_size_i(block_size_i), .timeout_i(timeout_i), .irq_ack_i(irq_ack_i),
    .dma_req_o(dma_req_o), .dma_ack_i(dma_ack_i), .dma_addr_o(dma_addr_o),
    .dma_len_o(dma_len_o), .dma_done_i(dma_done_i), .irq_o(irq_o),
    .irq_status_o(irq_status_o), .smpl_count_o(smpl_count_o),
`ifdef PCAP_DMA_STATS_EN
    .total_words_o(total_words_o), .buffers_o(buffers_o),
`endif
    .active_o(active_o)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } burst_t;

  burst_t      exp_burst_q[$];
  int          exp_close_q[$];
  logic [31:0] tbl_model[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  acc_status;
  logic [7:0]  exp_ovf;
  bit          mon_ack_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // Reference: walk the table, fill each buffer in whole bursts, remainder last
  task automatic model_episode(input int n, input int bwords, output logic [7:0] st);
    int rem = n;
    int fill;
    int len;
    logic [31:0] base;
    burst_t b;
    st = 8'h00;
    forever begin
      if (tbl_model.size() == 0) begin
        st |= 8'h08;
        return;
      end
      base = tbl_model.pop_front();
      fill = 0;
      while (rem > 0 && fill < bwords) begin
        len    = min3(BURST, rem, bwords - fill);
        b.addr = base + 32'(4 * fill);
        b.len  = 8'(len);
        exp_burst_q.push_back(b);
        fill += len;
        rem  -= len;
      end
      exp_close_q.push_back(fill);
      st |= 8'h01;
      if (fill < bwords) begin
        st |= 8'h02;
        return;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_addr(input logic [31:0] a);
    dma_addr_i      = a;
    dma_addr_wstb_i = 1'b1;
    tick();
    dma_addr_wstb_i = 1'b0;
    if (tbl_model.size() < 8) tbl_model.push_back(a);
    else exp_ovf = 8'h10;
  endtask

  task automatic finish_episode(input string name, input logic [7:0] st);
    int cyc = 0;
    repeat (2) tick();
    while (active_o && cyc < 20000) begin
      tick();
      cyc++;
    end
    if (active_o) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: active_o still 1 after %0d cycles, expected 0", name, cyc);
    end
    repeat (2) tick();
    check({name, "_bursts_left"}, exp_burst_q.size(), 0);
    check({name, "_closes_left"}, exp_close_q.size(), 0);
    check({name, "_status_seen"}, acc_status, st | exp_ovf);
    exp_burst_q.delete();
    exp_close_q.delete();
    enable_i   = 1'b0;
    complete_i = 1'b0;
    avail      = 0;
    ack_dir    = 1'b1;
    tick();
    ack_dir    = 1'b0;
    check({name, "_status_acked"}, irq_status_o, 8'h00);
    check({name, "_irq_acked"}, irq_o, 1'b0);
    tick();
  endtask

  task automatic start_episode(input int bwords, input int tmo);
    acc_status   = 8'h00;
    exp_ovf      = 8'h00;
    block_size_i = 32'(bwords * 4);
    timeout_i    = 32'(tmo);
  endtask

  task automatic run_random(input int idx, input int nb, input int n, input int bwords);
    logic [7:0] st;
    int pushed = 0;
    int chunk;
    start_episode(bwords, 0);
    for (int i = 0; i < nb; i++) push_addr($urandom & 32'hFFFF_FFFC);
    model_episode(n, bwords, st);
    enable_i = 1'b1;
    tick();
    while (pushed < n) begin
      chunk = $urandom_range(1, 40);
      if (chunk > n - pushed) chunk = n - pushed;
      avail  += chunk;
      pushed += chunk;
      repeat ($urandom_range(1, 8)) tick();
    end
    complete_i = 1'b1;
    finish_episode($sformatf("rand%0d", idx), st);
  endtask

  // Monitor: scores every accepted burst and every buffer close
  initial begin : monitor
    logic   prev_b0 = 1'b0;
    burst_t b;
    int     c;
    ack_mon = 1'b0;
    forever begin
      @(negedge clk_i);
      ack_mon = 1'b0;
      if (reset_i) begin
        prev_b0 = 1'b0;
        continue;
      end
      acc_status |= irq_status_o;
      check("irq_level", irq_o, |irq_status_o);
      if (dma_req_o && dma_ack_i) begin
        if (exp_burst_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL burst_unexpected: got addr 0x%08h len %0d, expected no burst", dma_addr_o, dma_len_o);
        end else begin
          b = exp_burst_q.pop_front();
          check("burst_addr", dma_addr_o, b.addr);
          check("burst_len", dma_len_o, b.len);
        end
      end
      if (irq_status_o[0] && !prev_b0) begin
        if (exp_close_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL close_unexpected: got smpl_count %0d, expected no close", smpl_count_o);
        end else begin
          c = exp_close_q.pop_front();
          check("smpl_count", smpl_count_o, c);
        end
        if (mon_ack_en) ack_mon = 1'b1;
      end
      prev_b0 = irq_status_o[0];
    end
  end

  // Write engine: acks a request after a random delay, reports done later
  initial begin : engine
    int l;
    dma_ack_i  = 1'b0;
    dma_done_i = 1'b0;
    forever begin
      tick();
      if (dma_req_o && !reset_i) begin
        repeat ($urandom_range(0, 3)) tick();
        dma_ack_i = 1'b1;
        l = int'(dma_len_o);
        tick();
        dma_ack_i = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        dma_done_i = 1'b1;
        avail -= l;
        tick();
        dma_done_i = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0]  st;
    logic [31:0] base;
    burst_t      b;
    int          cnt;
    reset_i = 1'b1; enable_i = 1'b0; complete_i = 1'b0;
    dma_addr_i = '0; dma_addr_wstb_i = 1'b0; block_size_i = 32'd64;
    timeout_i = '0; ack_dir = 1'b0; avail = 0;
    acc_status = '0; exp_ovf = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_req", dma_req_o, 1'b0);
    check("rst_addr", dma_addr_o, 32'h0);
    check("rst_len", dma_len_o, 8'h0);
    check("rst_irq", irq_o, 1'b0);
    check("rst_status", irq_status_o, 8'h00);
    check("rst_smpl", smpl_count_o, 16'h0);
    check("rst_active", active_o, 1'b0);
    reset_i = 1'b0;
    repeat (2) tick();

    // Arm with an empty table: underrun, no bursts
    start_episode(64, 0);
    model_episode(0, 64, st);
    enable_i = 1'b1;
    repeat (4) tick();
    check("underrun_status", irq_status_o, 8'h08);
    check("underrun_irq", irq_o, 1'b1);
    finish_episode("underrun", st);

    // Nine pushes: one dropped; ack coincident with a BUF_DONE
    start_episode(64, 0);
    for (int i = 0; i < 9; i++) push_addr(32'h2000_0000 + 32'(i) * 32'h400);
    check("overflow_status", irq_status_o, 8'h10);
    mon_ack_en = 1'b0;
    model_episode(0, 64, st);
    complete_i = 1'b1;
    enable_i   = 1'b1;
    repeat (3) tick();
    ack_dir = 1'b1;
    tick();
    ack_dir = 1'b0;
    check("ack_coincident_status", irq_status_o, 8'h03);
    finish_episode("ovf_ack", st);
    mon_ack_en = 1'b1;

    // Timeout flush of a 5-word residue
    start_episode(64, 100);
    base   = tbl_model.pop_front();
    b.addr = base;
    b.len  = 8'd5;
    exp_burst_q.push_back(b);
    exp_close_q.push_back(5);
    enable_i = 1'b1;
    repeat (3) tick();
    avail = 5;
    cnt   = 0;
    while (cnt < 300) begin
      tick();
      cnt++;
      if (dma_req_o) break;
    end
    check("timeout_latency", cnt, 100);
    cnt = 0;
    while (avail != 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    complete_i = 1'b1;
    finish_episode("timeout", 8'h07);

    // Disarm while a burst is in flight: burst completes, no COMPLETED flag
    start_episode(64, 0);
    base   = tbl_model.pop_front();
    b.addr = base;
    b.len  = 8'd16;
    exp_burst_q.push_back(b);
    exp_close_q.push_back(16);
    avail    = 16;
    enable_i = 1'b1;
    cnt      = 0;
    while (cnt < 50) begin
      @(negedge clk_i);
      cnt++;
      if (dma_req_o && dma_ack_i) break;
    end
    tick();
    enable_i = 1'b0;
    finish_episode("disarm", 8'h21);

    for (int e = 0; e < 14; e++) begin
      int bw;
      case ($urandom_range(0, 2))
        0:       bw = 16;
        1:       bw = 32;
        default: bw = 64;
      endcase
      run_random(e, $urandom_range(0, 3), $urandom_range(0, 150), bw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
